// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs symbolic instruction beats into 32-bit words and writes them into
// instruction memory from address 0. Optional macro HALT_APPEND_EN appends a 32'hFFFF_FFFF terminator word.
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_kind,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic                  in_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  done,
    output logic                  err_illegal,
    output logic                  err_full
);
    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LAST_V  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] ONE_V   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_END  = 2'd2
`ifdef HALT_APPEND_EN
        , ST_HALT = 2'd3
`endif
    } state_t;

`ifdef HALT_APPEND_EN
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam state_t ST_AFTER_LAST = ST_HALT;
`else
    localparam state_t ST_AFTER_LAST = ST_END;
`endif

    function automatic logic [31:0] encode_word(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm
    );
        logic [31:0] word;
        case (kind)
            3'd0:    word = {6'b000000, rs, rt, rd, 5'b00000, funct};
            3'd1:    word = {6'b000001, rs, rt, imm};
            3'd2:    word = {6'b000010, rs, rt, imm};
            3'd3:    word = {6'b000011, rs, rt, imm};
            3'd4:    word = {6'b000100, rs, rt, imm};
            default: word = 32'h0000_0000;
        endcase
        return word;
    endfunction

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_WIDTH:0] wptr_r;
    logic [ADDR_WIDTH:0] count_r;
    logic                in_ready_s;
    logic                accept_s;
    logic                legal_s;
    logic                wr_s;
    logic [31:0]         wdata_s;
    logic                clear_s;
    logic                set_ill_s;
    logic                set_full_s;
    logic                imem_we_r;
    logic [ADDR_WIDTH-1:0] imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                done_r;
    logic                err_ill_r;
    logic                err_full_r;

    assign in_ready_s = (state_r == ST_LOAD) && (count_r < DEPTH_V);
    assign accept_s   = in_valid && in_ready_s;
    assign legal_s    = (in_kind <= 3'd4);

    assign in_ready    = in_ready_s;
    assign imem_we     = imem_we_r;
    assign imem_addr   = imem_addr_r;
    assign imem_wdata  = imem_wdata_r;
    assign count       = count_r;
    assign done        = done_r;
    assign err_illegal = err_ill_r;
    assign err_full    = err_full_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and per-cycle write/flag decisions
    always_comb begin
        state_nxt_s = state_r;
        wr_s        = 1'b0;
        wdata_s     = encode_word(in_kind, in_rs, in_rt, in_rd, in_funct, in_imm);
        clear_s     = 1'b0;
        set_ill_s   = 1'b0;
        set_full_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    wr_s      = legal_s;
                    set_ill_s = ~legal_s;
                    // A last beat ends normally even if it also fills memory.
                    if (in_last) begin
                        state_nxt_s = ST_AFTER_LAST;
                    end else if (legal_s && (count_r == LAST_V)) begin
                        state_nxt_s = ST_END;
                        set_full_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
`ifdef HALT_APPEND_EN
            ST_HALT: begin
                wdata_s = HALT_WORD;
                if (count_r < DEPTH_V) begin
                    wr_s = 1'b1;
                end else begin
                    set_full_s = 1'b1;
                end
                state_nxt_s = ST_END;
            end
`endif
            ST_END: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Registered memory port, counters and sticky session flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_WIDTH{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
            wptr_r       <= {(ADDR_WIDTH+1){1'b0}};
            count_r      <= {(ADDR_WIDTH+1){1'b0}};
            done_r       <= 1'b0;
            err_ill_r    <= 1'b0;
            err_full_r   <= 1'b0;
        end else begin
            imem_we_r <= wr_s;
            done_r    <= (state_r == ST_END);
            if (clear_s) begin
                wptr_r     <= {(ADDR_WIDTH+1){1'b0}};
                count_r    <= {(ADDR_WIDTH+1){1'b0}};
                err_ill_r  <= 1'b0;
                err_full_r <= 1'b0;
            end else begin
                if (wr_s) begin
                    imem_addr_r  <= wptr_r[ADDR_WIDTH-1:0];
                    imem_wdata_r <= wdata_s;
                    wptr_r       <= wptr_r + ONE_V;
                    count_r      <= count_r + ONE_V;
                end
                if (set_ill_s) begin
                    err_ill_r <= 1'b1;
                end
                if (set_full_s) begin
                    err_full_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Encoder counterpart to the opcode control decoder.
- Accepts symbolic instruction beats (kind plus register and immediate fields) over a valid/ready handshake.
- Packs each beat into a 32-bit instruction word using the team opcode map.
- Writes the words into instruction memory at consecutive addresses starting at 0.
- Used by benches and boot logic to load programs that the non-pipelined CPU then fetches and decodes.

## Interface
- ADDR_WIDTH, 8, instruction memory word-address width; DEPTH = 2**ADDR_WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a load session from IDLE.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- in_kind  in  3  0=R, 1=LW, 2=SW, 3=BR, 4=ADDI, 5..7 illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_funct  in  6  R-type funct.
- in_imm  in  16  immediate/offset.
- in_last  in  1  marks final beat of session.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_WIDTH  write address.
- imem_wdata  out  32  encoded word.
- count  out  ADDR_WIDTH+1  words written this session.
- done  out  1  one-cycle pulse at session end.
- err_illegal  out  1  sticky; an illegal kind was received this session.
- err_full  out  1  sticky; session ended because memory filled.

## Operation
Encoding:
- R = {6'b000000, rs, rt, rd, 5'b0, funct}.
- LW/SW/BR/ADDI = {opcode, rs, rt, imm}, with opcodes 000001, 000010, 000011, 000100 respectively.
- Unused input fields are ignored.

State machine:
- IDLE -> LOAD on start. Entering LOAD clears wptr, count and both error flags.
- LOAD:
  - in_ready = 1 while count < DEPTH.
  - Accepted legal beat: write the word at wptr, then increment wptr and count.
  - Accepted illegal beat: consumed with no write; sets err_illegal.
  - Accepted beat with in_last: -> END (END is HALT when HALT_APPEND_EN is defined).
  - count reaches DEPTH without in_last: -> END, sets err_full.
- HALT, present only when HALT_APPEND_EN is defined: writes one terminator word, then -> END.
- END: done = 1 for one cycle, in_ready = 0, then -> IDLE.

Rules:
- start outside IDLE is ignored.
- count, err_illegal and err_full hold their values in IDLE until the next start.

## Timing
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err_illegal=0, err_full=0. State = IDLE, wptr = 0.
- in_ready is combinational from state and count; it is 0 in IDLE, HALT and END.
- Write latency is 1 cycle: a beat accepted at edge N drives imem_we, imem_addr and imem_wdata registered after edge N. count is updated at the same edge.
- Throughput is one word per cycle under continuous in_valid.
- done rises the cycle after the final write, or after the final accept when that beat was illegal.
- Wrap-around: a write at address DEPTH-1 makes count = DEPTH. wptr never wraps within a session.
- in_last on the beat that also fills memory: err_full = 0, because the session ended normally.
- Reset asserted mid-session aborts immediately to IDLE with all outputs at their reset values. Words already written stay in memory.

## Configuration
- HALT_APPEND_EN defined:
  - After an in_last beat, one extra word 32'hFFFF_FFFF (opcode 111111, decoded as the default control case) is written at the next address, and count increments.
  - If memory is already full, the append is skipped and err_full is set.
- HALT_APPEND_EN undefined: no HALT state and no terminator word.

## Test plan
- Reset, start, then ADDI rs=1 rt=2 imm=16'h0005 with in_last -> one write, addr 0, data 32'h1022_0005; done one cycle later; count=1.
- Back-to-back R (rs=1, rt=2, rd=3, funct=6'h20), LW (rs=0, rt=4, imm=8), BR (rs=4, rt=0, imm=16'hFFFE), last -> writes on 3 consecutive cycles:
  - addr 0: 32'h0022_1820
  - addr 1: 32'h0404_0008
  - addr 2: 32'h0C80_FFFE
- Illegal kind 6 mid-stream -> no write and no address advance; err_illegal=1; following legal beats land at contiguous addresses.
- ADDR_WIDTH=2, five beats with no last -> four writes to addr 0..3, in_ready falls, err_full=1, done pulses, fifth beat not accepted.
- rst_n pulled low during LOAD after two writes -> outputs at reset values immediately. A new start rewrites from addr 0.
- HALT_APPEND_EN defined, single SW beat (rs=2, rt=3, imm=4) with last -> addr 0 = 32'h0843_0004, addr 1 = 32'hFFFF_FFFF, count=2.
